// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: funct3 widths, FSM states, timeout default
// and small helpers that classify access width and lane offset.
package mem_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mau_state_e;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10
    } width_e;

    // Unsigned encodings exist only for loads; any unlisted code is a word access.
    function automatic width_e access_width(input logic [2:0] funct3, input logic is_store);
        width_e w;
        case (funct3)
            F3_BYTE:   w = W_BYTE;
            F3_HALF:   w = W_HALF;
            F3_BYTE_U: w = is_store ? W_WORD : W_BYTE;
            F3_HALF_U: w = is_store ? W_WORD : W_HALF;
            default:   w = W_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] lane_offset(input width_e w, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (w)
            W_BYTE:  off = addr_lo;
            W_HALF:  off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic is_misaligned(input width_e w, input logic [1:0] addr_lo);
        logic mis;
        case (w)
            W_HALF:  mis = addr_lo[0];
            W_WORD:  mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load formatter: picks the byte/half lane from a RAM word and
// sign- or zero-extends it according to funct3.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    width_e      width_s;

    // Lane extraction followed by extension; funct3[2] marks the unsigned forms.
    always_comb begin
        width_s = access_width(funct3, 1'b0);
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (width_s)
            W_BYTE:  data = funct3[2] ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            W_HALF:  data = funct3[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: issues one RAM request per load/store, stalls upstream until it completes.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_alu_rd_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd_address,
    input  logic        in_reg_write_data_src,
    input  logic        in_reg_write_enable,
    input  logic [31:0] in_next_pc_data,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        out_valid,
    output logic [31:0] out_ram_data,
    output logic [31:0] out_alu_rd_result,
    output logic [4:0]  out_rd_address,
    output logic        out_reg_write_data_src,
    output logic        out_reg_write_enable,
    output logic [31:0] out_next_pc_data,
    output logic        mem_stall,
    output logic        misalign_fault,
    output logic        bus_fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mau_state_e  state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, cnt_inc_s;
    logic [31:0] load_r, load_next_s;
    logic        bus_fault_r, bus_fault_next_s;
    logic        misalign_r, misalign_next_s;
    logic        capture_s, req_s, mem_op_s, misalign_s;

    logic [31:0] h_addr_r, h_data_r, h_pc_r;
    logic        h_read_r, h_write_r, h_src_r, h_we_r;
    logic [2:0]  h_funct3_r;
    logic [4:0]  h_rd_r;

    logic [31:0] sel_addr_s, sel_data_s, aligned_s, wdata_s;
    logic        sel_read_s, sel_write_s;
    logic [2:0]  sel_funct3_s;
    logic [1:0]  offset_s;
    logic [3:0]  strb_s;
    width_e      width_s;

    assign mem_op_s  = in_valid & (in_mem_read | in_mem_write);
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Live inputs drive the request in IDLE; held copies keep it stable afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_addr_s   = in_alu_rd_result;
            sel_data_s   = in_store_data;
            sel_read_s   = in_mem_read;
            sel_write_s  = in_mem_write;
            sel_funct3_s = in_funct3;
        end else begin
            sel_addr_s   = h_addr_r;
            sel_data_s   = h_data_r;
            sel_read_s   = h_read_r;
            sel_write_s  = h_write_r;
            sel_funct3_s = h_funct3_r;
        end
    end

    assign width_s  = access_width(sel_funct3_s, sel_write_s);
    assign offset_s = lane_offset(width_s, sel_addr_s[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(width_s, sel_addr_s[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    load_aligner u_load_aligner (
        .rdata  (ram_rdata),
        .funct3 (sel_funct3_s),
        .offset (offset_s),
        .data   (aligned_s)
    );

    // Store strobes and lane-replicated write data.
    always_comb begin
        case (width_s)
            W_BYTE: begin
                strb_s  = 4'b0001 << offset_s;
                wdata_s = {4{sel_data_s[7:0]}};
            end
            W_HALF: begin
                strb_s  = 4'b0011 << {offset_s[1], 1'b0};
                wdata_s = {2{sel_data_s[15:0]}};
            end
            default: begin
                strb_s  = 4'b1111;
                wdata_s = sel_data_s;
            end
        endcase
    end

    // Next-state, timeout counter, load register and fault flag updates.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        load_next_s      = load_r;
        bus_fault_next_s = 1'b0;
        misalign_next_s  = 1'b0;
        capture_s        = 1'b0;
        req_s            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (mem_op_s) begin
                    capture_s = 1'b1;
                    if (misalign_s) begin
                        state_next_s    = ST_DONE;
                        misalign_next_s = 1'b1;
                        load_next_s     = 32'h0;
                    end else if (ram_ready) begin
                        req_s        = 1'b1;
                        state_next_s = ST_DONE;
                        load_next_s  = sel_read_s ? aligned_s : 32'h0;
                    end else begin
                        req_s        = 1'b1;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                req_s = 1'b1;
                if (ram_ready) begin
                    state_next_s = ST_DONE;
                    load_next_s  = sel_read_s ? aligned_s : 32'h0;
                end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_next_s     = ST_DONE;
                    bus_fault_next_s = 1'b1;
                    load_next_s      = 32'h0;
                    cnt_next_s       = cnt_inc_s;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            load_r      <= 32'h0;
            bus_fault_r <= 1'b0;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            load_r      <= load_next_s;
            bus_fault_r <= bus_fault_next_s;
            misalign_r  <= misalign_next_s;
        end
    end

    // Hold the EX/MEM entry for the duration of an access.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_addr_r   <= 32'h0;
            h_data_r   <= 32'h0;
            h_pc_r     <= 32'h0;
            h_read_r   <= 1'b0;
            h_write_r  <= 1'b0;
            h_src_r    <= 1'b0;
            h_we_r     <= 1'b0;
            h_funct3_r <= 3'b000;
            h_rd_r     <= 5'd0;
        end else if (capture_s) begin
            h_addr_r   <= in_alu_rd_result;
            h_data_r   <= in_store_data;
            h_pc_r     <= in_next_pc_data;
            h_read_r   <= in_mem_read;
            h_write_r  <= in_mem_write;
            h_src_r    <= in_reg_write_data_src;
            h_we_r     <= in_reg_write_enable;
            h_funct3_r <= in_funct3;
            h_rd_r     <= in_rd_address;
        end else begin
            h_addr_r <= h_addr_r;
        end
    end

    // RAM request port; quiet whenever no request is active.
    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        ram_wstrb = 4'h0;
        if (req_s && !reset) begin
            ram_req   = 1'b1;
            ram_we    = sel_write_s;
            ram_addr  = {sel_addr_s[31:2], 2'b00};
            ram_wdata = sel_write_s ? wdata_s : 32'h0;
            ram_wstrb = sel_write_s ? strb_s : 4'h0;
        end else begin
            ram_req = 1'b0;
        end
    end

    // MEM/WB side: pass-through in IDLE, held entry once an access is in flight.
    always_comb begin
        out_valid              = 1'b0;
        mem_stall              = 1'b0;
        out_ram_data           = 32'h0;
        out_alu_rd_result      = h_addr_r;
        out_rd_address         = h_rd_r;
        out_reg_write_data_src = h_src_r;
        out_reg_write_enable   = h_we_r;
        out_next_pc_data       = h_pc_r;
        if (reset) begin
            out_valid = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid              = in_valid & ~mem_op_s;
                    mem_stall              = mem_op_s;
                    out_alu_rd_result      = in_alu_rd_result;
                    out_rd_address         = in_rd_address;
                    out_reg_write_data_src = in_reg_write_data_src;
                    out_reg_write_enable   = in_reg_write_enable;
                    out_next_pc_data       = in_next_pc_data;
                end
                ST_WAIT: mem_stall = 1'b1;
                ST_DONE: begin
                    out_valid            = 1'b1;
                    out_ram_data         = h_read_r ? load_r : 32'h0;
                    out_reg_write_enable = h_we_r & ~bus_fault_r & ~misalign_r;
                end
                default: out_valid = 1'b0;
            endcase
        end
    end

    assign bus_fault      = bus_fault_r;
    assign misalign_fault = misalign_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [31:0] in_alu_rd_result, in_store_data, in_next_pc_data;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd_address;
    logic        in_reg_write_data_src, in_reg_write_enable;
    logic        ram_req, ram_we, ram_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wstrb;
    logic        out_valid, out_reg_write_data_src, out_reg_write_enable;
    logic [31:0] out_ram_data, out_alu_rd_result, out_next_pc_data;
    logic [4:0]  out_rd_address;
    logic        mem_stall, misalign_fault, bus_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_alu_rd_result(in_alu_rd_result), .in_store_data(in_store_data),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
        .in_rd_address(in_rd_address), .in_reg_write_data_src(in_reg_write_data_src),
        .in_reg_write_enable(in_reg_write_enable), .in_next_pc_data(in_next_pc_data),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_ram_data(out_ram_data), .out_alu_rd_result(out_alu_rd_result),
        .out_rd_address(out_rd_address), .out_reg_write_data_src(out_reg_write_data_src),
        .out_reg_write_enable(out_reg_write_enable), .out_next_pc_data(out_next_pc_data),
        .mem_stall(mem_stall), .misalign_fault(misalign_fault), .bus_fault(bus_fault)
    );

    task automatic idle_inputs();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = 3'b000;
        in_alu_rd_result = 32'h0; in_store_data = 32'h0; in_next_pc_data = 32'h0;
        in_rd_address = 5'd0; in_reg_write_data_src = 1'b0; in_reg_write_enable = 1'b0;
        ram_ready = 1'b0; ram_rdata = 32'h0;
    endtask

    // Runs one memory op; ram_ready rises 'delay' cycles after the request cycle.
    task automatic do_access(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int delay,
                             output int stalls, output logic req_seen, output logic [31:0] req_addr,
                             output logic req_we, output logic [3:0] req_wstrb,
                             output logic [31:0] req_wdata, output logic req_stable,
                             output logic done_seen, output logic [31:0] done_data,
                             output logic done_we, output logic done_bus, output logic done_mis,
                             output logic [31:0] done_alu);
        int cyc;
        stalls = 0; req_seen = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wstrb = 4'h0;
        req_wdata = 32'h0; req_stable = 1'b1; done_seen = 1'b0; done_data = 32'h0;
        done_we = 1'b0; done_bus = 1'b0; done_mis = 1'b0; done_alu = 32'h0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mem_read = rd_op; in_mem_write = wr_op; in_funct3 = f3;
        in_alu_rd_result = addr; in_store_data = sdata; in_next_pc_data = addr + 32'd4;
        in_rd_address = 5'd7; in_reg_write_enable = 1'b1; in_reg_write_data_src = 1'b1;
        ram_rdata = rdata; ram_ready = (delay == 0);
        cyc = 0;
        while (!done_seen && cyc < 20) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            if (ram_req) begin
                if (!req_seen) begin
                    req_addr = ram_addr; req_we = ram_we; req_wstrb = ram_wstrb; req_wdata = ram_wdata;
                end else if (ram_addr !== req_addr || ram_wdata !== req_wdata || ram_wstrb !== req_wstrb) begin
                    req_stable = 1'b0;
                end
                req_seen = 1'b1;
            end
            if (out_valid) begin
                done_seen = 1'b1; done_data = out_ram_data; done_we = out_reg_write_enable;
                done_bus = bus_fault; done_mis = misalign_fault; done_alu = out_alu_rd_result;
            end else begin
                @(posedge clk); #1;
                cyc++;
                ram_ready = (cyc == delay);
                in_alu_rd_result = 32'hDEAD_BEE0;
                in_store_data = 32'h5555_AAAA;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_alu_rd_result = 32'h100; ram_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall: got %b want 0", mem_stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (out_ram_data !== 32'h0) begin errors++; $display("FAIL reset_out_ram_data: got %h want 0", out_ram_data); end
        checks++; if ({bus_fault, misalign_fault, mem_stall, out_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {bus_fault, misalign_fault, mem_stall, out_valid}); end
    endtask

    task automatic test_nonmem();
        @(posedge clk); #1;
        idle_inputs();
        in_valid = 1'b1; in_alu_rd_result = 32'h1234_5678; in_rd_address = 5'd19;
        in_next_pc_data = 32'h0000_4004; in_reg_write_enable = 1'b1; in_reg_write_data_src = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid: got %b want 1", out_valid); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b want 0", mem_stall); end
        checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL nonmem_req: got %b want 0", ram_req); end
        checks++; if (out_alu_rd_result !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_alu: got %h want 12345678", out_alu_rd_result); end
        checks++; if (out_rd_address !== 5'd19 || out_next_pc_data !== 32'h0000_4004 || out_reg_write_enable !== 1'b1) begin
            errors++; $display("FAIL nonmem_sideband: got rd %0d pc %h we %b want 19 00004004 1", out_rd_address, out_next_pc_data, out_reg_write_enable); end
        checks++; if (out_ram_data !== 32'h0) begin errors++; $display("FAIL nonmem_ram_data: got %h want 0", out_ram_data); end
    endtask

    task automatic test_lw_fast();
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_BABE, 0,
                  st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
        checks++; if (ds !== 1'b1) begin errors++; $display("FAIL lw_done: got %b want 1", ds); end
        checks++; if (st != 1) begin errors++; $display("FAIL lw_stalls: got %0d want 1", st); end
        checks++; if (ra !== 32'h100 || rwe !== 1'b0) begin errors++; $display("FAIL lw_req: got addr %h we %b want 00000100 0", ra, rwe); end
        checks++; if (dd !== 32'hCAFE_BABE) begin errors++; $display("FAIL lw_data: got %h want cafebabe", dd); end
        checks++; if (dwe !== 1'b1 || out_rd_address !== 5'd7) begin errors++; $display("FAIL lw_wb: got we %b rd %0d want 1 7", dwe, out_rd_address); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_single_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3_t [0:6];
        logic [31:0] ad_t [0:6];
        logic [31:0] rd_t [0:6];
        logic [31:0] ex_t [0:6];
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        f3_t = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b111};
        ad_t = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h104};
        rd_t = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_1234, 32'h8001_1234, 32'h0000_7F00, 32'h1234_5678, 32'hA5A5_0F0F};
        ex_t = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F, 32'h0000_5678, 32'hA5A5_0F0F};
        for (int i = 0; i < 7; i++) begin
            do_access(1'b1, 1'b0, f3_t[i], ad_t[i], 32'h0, rd_t[i], i % 2,
                      st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
            checks++; if (dd !== ex_t[i] || ds !== 1'b1) begin
                errors++; $display("FAIL load_fmt[%0d]: got %h done %b want %h", i, dd, ds, ex_t[i]); end
            checks++; if (ra !== {ad_t[i][31:2], 2'b00}) begin
                errors++; $display("FAIL load_addr[%0d]: got %h want %h", i, ra, {ad_t[i][31:2], 2'b00}); end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_stores();
        logic [2:0]  f3_t [0:4];
        logic [31:0] ad_t [0:4];
        logic [31:0] sd_t [0:4];
        logic [3:0]  sb_t [0:4];
        logic [31:0] wd_t [0:4];
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        f3_t = '{3'b001, 3'b000, 3'b010, 3'b001, 3'b000};
        ad_t = '{32'h102, 32'h101, 32'h200, 32'h100, 32'h103};
        sd_t = '{32'h0000_BEEF, 32'h1234_5678, 32'h1122_3344, 32'h0000_ABCD, 32'hFFFF_FF5A};
        sb_t = '{4'b1100, 4'b0010, 4'b1111, 4'b0011, 4'b1000};
        wd_t = '{32'hBEEF_BEEF, 32'h7878_7878, 32'h1122_3344, 32'hABCD_ABCD, 32'h5A5A_5A5A};
        for (int i = 0; i < 5; i++) begin
            do_access(1'b0, 1'b1, f3_t[i], ad_t[i], sd_t[i], 32'hFFFF_FFFF, 0,
                      st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
            checks++; if (rstb !== sb_t[i] || rwd !== wd_t[i] || rwe !== 1'b1) begin
                errors++; $display("FAIL store[%0d]: got strb %b wdata %h we %b want %b %h 1", i, rstb, rwd, rwe, sb_t[i], wd_t[i]); end
            checks++; if (dd !== 32'h0 || ds !== 1'b1) begin
                errors++; $display("FAIL store_ram_data[%0d]: got %h done %b want 0 1", i, dd, ds); end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_wait_latency();
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        do_access(1'b1, 1'b0, 3'b010, 32'h240, 32'h0, 32'h0BAD_F00D, 3,
                  st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
        checks++; if (st != 4) begin errors++; $display("FAIL wait_stalls: got %0d want 4", st); end
        checks++; if (stb !== 1'b1 || ra !== 32'h240) begin errors++; $display("FAIL wait_req_stable: got stable %b addr %h want 1 00000240", stb, ra); end
        checks++; if (dd !== 32'h0BAD_F00D || dalu !== 32'h240) begin
            errors++; $display("FAIL wait_done: got data %h alu %h want 0badf00d 00000240", dd, dalu); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_timeout();
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 100,
                  st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
        checks++; if (ds !== 1'b1 || st != 5) begin errors++; $display("FAIL timeout_stalls: got done %b stalls %0d want 1 5", ds, st); end
        checks++; if (db !== 1'b1) begin errors++; $display("FAIL timeout_bus_fault: got %b want 1", db); end
        checks++; if (dwe !== 1'b0 || dd !== 32'h0) begin errors++; $display("FAIL timeout_wb: got we %b data %h want 0 0", dwe, dd); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus_fault !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", bus_fault); end
        do_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h3333_4444, 2,
                  st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
        checks++; if (dd !== 32'h3333_4444 || dwe !== 1'b1 || db !== 1'b0 || st != 3) begin
            errors++; $display("FAIL after_timeout: got data %h we %b bus %b stalls %0d want 33334444 1 0 3", dd, dwe, db, st); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_misalign();
        int st; logic rs, rwe, stb, ds, dwe, db, dm; logic [31:0] ra, rwd, dd, dalu; logic [3:0] rstb;
        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0,
                  st, rs, ra, rwe, rstb, rwd, stb, ds, dd, dwe, db, dm, dalu);
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (rs !== 1'b0 || st != 1) begin errors++; $display("FAIL misalign_req: got req %b stalls %0d want 0 1", rs, st); end
        checks++; if (dm !== 1'b1 || dwe !== 1'b0) begin errors++; $display("FAIL misalign_fault: got fault %b we %b want 1 0", dm, dwe); end
`else
        checks++; if (ra !== 32'h100 || rs !== 1'b1) begin errors++; $display("FAIL misalign_addr: got %h req %b want 00000100 1", ra, rs); end
        checks++; if (dd !== 32'h1122_3344 || dwe !== 1'b1 || dm !== 1'b0) begin
            errors++; $display("FAIL misalign_load: got data %h we %b fault %b want 11223344 1 0", dd, dwe, dm); end
`endif
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b want 0", misalign_fault); end
    endtask

    task automatic test_ready_outside();
        @(posedge clk); #1;
        idle_inputs();
        in_valid = 1'b1; ram_ready = 1'b1; ram_rdata = 32'h7777_7777;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || ram_req !== 1'b0) begin
            errors++; $display("FAIL stray_ready_nonmem: got valid %b req %b want 1 0", out_valid, ram_req); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({out_valid, mem_stall, ram_req} !== 3'b000 || out_ram_data !== 32'h0) begin
            errors++; $display("FAIL stray_ready_idle: got v/s/r %b data %h want 000 0", {out_valid, mem_stall, ram_req}, out_ram_data); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        idle_inputs();
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_alu_rd_result = 32'h400;
        ram_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ram_req !== 1'b1 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL rst_wait_pre: got req %b stall %b want 1 1", ram_req, mem_stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({ram_req, mem_stall, out_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_wait_during: got req/stall/valid %b want 000", {ram_req, mem_stall, out_valid}); end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if ({ram_req, mem_stall, out_valid} !== 3'b000 || out_ram_data !== 32'h0) begin
            errors++; $display("FAIL rst_wait_after: got req/stall/valid %b data %h want 000 0", {ram_req, mem_stall, out_valid}, out_ram_data); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lw_fast();
        test_load_formats();
        test_stores();
        test_wait_latency();
        test_timeout();
        test_misalign();
        test_ready_outside();
        test_reset_in_wait();
        test_lw_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for ram_ready before a bus fault.
REQ-002 SHALL have ports: clk  in  1  clock; single clock domain, all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  EX/MEM entry valid. in_alu_rd_result  in  32  ALU result, also the byte address. in_store_data  in  32  rs2 data.
REQ-005 in_mem_read / in_mem_write  in  1 each  load / store op; never both high. in_funct3  in  3  access width and signedness.
REQ-006 in_rd_address  in  5. in_reg_write_data_src  in  1. in_reg_write_enable  in  1. in_next_pc_data  in  32: sideband fields.
REQ-007 ram_req  out  1. ram_we  out  1. ram_addr  out  32 (low 2 bits 0). ram_wdata  out  32. ram_wstrb  out  4. ram_ready  in  1. ram_rdata  in  32.
REQ-008 out_valid  out  1: MEM/WB write enable. out_ram_data  out  32. out_alu_rd_result, out_rd_address, out_reg_write_data_src, out_reg_write_enable, out_next_pc_data: same widths as inputs.
REQ-009 mem_stall  out  1: hold upstream stages. misalign_fault  out  1. bus_fault  out  1: single-cycle pulses.

Function
REQ-010 FSM states: IDLE, WAIT, DONE.
REQ-011 Non-memory op in IDLE: out_valid = in_valid, same cycle; mem_stall = 0; sideband outputs = inputs combinationally.
REQ-012 Memory op in IDLE: ram_req = 1 and mem_stall = 1 in the same cycle; go to WAIT if ram_ready = 0, else to DONE.
REQ-013 WAIT: ram_req = 1, mem_stall = 1. Request fields are driven from the held inputs and stay stable until ram_ready. Go to DONE on ram_ready.
REQ-014 DONE: lasts one cycle; ram_req = 0, mem_stall = 0, out_valid = 1; return to IDLE.
REQ-015 Memory-op latency: stall cycles = (cycles until ram_ready) + 1; minimum stall is 1 cycle.
REQ-016 When ram_ready is high, ram_rdata SHALL be formatted and registered into the load register, which drives out_ram_data in DONE.
REQ-017 out_ram_data SHALL be 0 for stores and for non-memory ops.
REQ-018 Load format by in_funct3: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend. Lane select is addr[1:0].
REQ-019 Store strobes: SB 0001<<addr[1:0]; SH 0011<<(addr[1]*2); SW 1111. ram_wdata SHALL replicate the byte or half across all lanes.
REQ-020 Other funct3 codes SHALL be treated as word width.
REQ-021 Timeout counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES: go to DONE, pulse bus_fault, force out_reg_write_enable = 0 in DONE.
REQ-022 Counter SHALL clear on entry to IDLE.
REQ-023 ram_ready outside a request SHALL be ignored.

Reset
REQ-024 reset SHALL force: state = IDLE, counter = 0, load register = 0, fault pulses = 0. It SHALL override any in-flight access, dropping ram_req the next cycle.
REQ-025 During reset SHALL drive: out_valid = 0, ram_req = 0, mem_stall = 0.

Configuration
REQ-026 Macro MEM_MISALIGN_TRAP_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL NOT raise ram_req. It goes IDLE->DONE with 1 stall cycle, pulses misalign_fault in DONE, and forces out_reg_write_enable = 0.
REQ-027 Macro undefined: misalign_fault tied 0; offending low address bits are treated as 0 (forced alignment).

Structure
REQ-028 Package mem_pkg SHALL hold: funct3 width encodings, the FSM state enum, and the TIMEOUT_CYCLES default.
REQ-029 Combinational lane extraction and sign extension SHALL live in sub-module load_aligner.

Verification
REQ-030 LW addr 0x100, ram_ready in the request cycle -> 1 stall cycle; DONE out_ram_data = ram_rdata; out_valid pulses once.
REQ-031 LB addr 0x103, rdata 0x80FF_FF_FF -> out_ram_data 0xFFFFFF80. LBU same -> 0x00000080.
REQ-032 SH addr 0x102, data 0x0000BEEF -> ram_wstrb 1100, ram_wdata 0xBEEFBEEF, ram_we 1.
REQ-033 ram_ready withheld with TIMEOUT_CYCLES = 4 -> bus_fault pulse after 4 WAIT cycles; out_reg_write_enable 0; next op proceeds normally.
REQ-034 LW addr 0x101: with MEM_MISALIGN_TRAP_EN -> no ram_req, misalign_fault pulse, no reg write. Without it -> ram_addr 0x100, normal load.
REQ-035 reset asserted in WAIT -> next cycle IDLE, ram_req 0, mem_stall 0, out_ram_data 0.
